// File: rtl/switch_egress_arbiter.sv
// switch_egress_arbiter: per-output round-robin packet arbiter with valid/ready egress and stall timeout
module switch_egress_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_PORTS-1:0]                    req,
  input  logic [NUM_PORTS*NUM_PORTS-1:0]          req_target,
  input  logic [NUM_PORTS*DATA_W-1:0]             req_data,
  input  logic [NUM_PORTS-1:0]                    req_last,
  output logic [NUM_PORTS-1:0]                    grant,
  output logic [NUM_PORTS-1:0]                    out_valid,
  output logic [NUM_PORTS*DATA_W-1:0]             out_data,
  output logic [NUM_PORTS-1:0]                    out_last,
  input  logic [NUM_PORTS-1:0]                    out_ready,
  output logic [NUM_PORTS-1:0]                    out_busy,
  output logic [NUM_PORTS*$clog2(NUM_PORTS)-1:0]  out_owner,
  output logic [NUM_PORTS-1:0]                    timeout_pulse,
  output logic [NUM_PORTS-1:0]                    err_target
);
  localparam int OWN_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state [NUM_PORTS];
  state_t state_n [NUM_PORTS];
  logic [OWN_W-1:0] owner [NUM_PORTS];
  logic [OWN_W-1:0] owner_n [NUM_PORTS];
  logic [OWN_W-1:0] rr [NUM_PORTS];
  logic [OWN_W-1:0] rr_n [NUM_PORTS];
  logic [OWN_W-1:0] pick [NUM_PORTS];
  logic [CNT_W-1:0] cnt [NUM_PORTS];
  logic [CNT_W-1:0] cnt_n [NUM_PORTS];
  logic [NUM_PORTS-1:0] cand [NUM_PORTS];
  logic [NUM_PORTS-1:0] onehot, found, xfer, to_n, err_n;
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      onehot[i] = $onehot(req_target[i*NUM_PORTS +: NUM_PORTS]);
      err_n[i] = req[i] && !onehot[i];
    end
    for (int o = 0; o < NUM_PORTS; o++)
      for (int i = 0; i < NUM_PORTS; i++)
        cand[o][i] = req[i] && onehot[i] && req_target[i*NUM_PORTS + o];
  end
  // Scan downward so the last hit is the nearest candidate after rr
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      found[o] = 1'b0;
      pick[o] = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
        int idx;
        idx = (int'(rr[o]) + k) % NUM_PORTS;
        if (cand[o][idx]) begin
          found[o] = 1'b1;
          pick[o] = OWN_W'(idx);
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state[o] <= IDLE;
        owner[o] <= '0;
        rr[o] <= OWN_W'(NUM_PORTS - 1);
        cnt[o] <= '0;
      end
      timeout_pulse <= '0;
      err_target <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr <= rr_n;
      cnt <= cnt_n;
      timeout_pulse <= to_n;
      err_target <= err_n;
    end
  end
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_n[o] = state[o];
      owner_n[o] = owner[o];
      rr_n[o] = rr[o];
      cnt_n[o] = cnt[o];
      to_n[o] = 1'b0;
      if (state[o] == IDLE) begin
        if (found[o]) begin
          state_n[o] = BUSY;
          owner_n[o] = pick[o];
        end
      end else if (xfer[o]) begin
        cnt_n[o] = '0;
        if (out_last[o]) begin
          state_n[o] = IDLE;
          owner_n[o] = '0;
          rr_n[o] = owner[o];
        end
      end else if (cnt[o] == CNT_W'(TIMEOUT - 1)) begin
        state_n[o] = IDLE;
        owner_n[o] = '0;
        rr_n[o] = owner[o];
        cnt_n[o] = '0;
        to_n[o] = 1'b1;
      end else begin
        cnt_n[o] = cnt[o] + 1'b1;
      end
    end
  end
  // Beats are suppressed during reset so nothing is consumed at the reset edge
  always_comb begin
    grant = '0;
    out_valid = '0;
    out_data = '0;
    out_last = '0;
    out_busy = '0;
    out_owner = '0;
    xfer = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_busy[o] = state[o] == BUSY;
      out_owner[o*OWN_W +: OWN_W] = owner[o];
      out_valid[o] = rst_n && state[o] == BUSY && cand[o][owner[o]];
      out_data[o*DATA_W +: DATA_W] = out_valid[o] ? req_data[int'(owner[o])*DATA_W +: DATA_W] : '0;
      out_last[o] = out_valid[o] && req_last[owner[o]];
      xfer[o] = out_valid[o] && out_ready[o];
      grant[owner[o]] = grant[owner[o]] | xfer[o];
    end
  end
endmodule
